// File: rtl/speed_counter_if.sv
// ---------------------------------------------------------------------------
// speed_counter_if
//   Bundles the command pair coming from the speed-control FSM together with
//   the speed / rate outputs of speed_counter.
//
//   Signals:
//     ENABLE   step request; a step is taken on its 0->1 transition
//     UP_DOWN  direction sampled with ENABLE (0 = increment, 1 = decrement)
//     SPEED    current speed level, WIDTH bits
//     TICK     one-cycle rate strobe
//     CHANGED  one-cycle pulse when SPEED takes a new value
//     AT_MAX   SPEED is at the top level
//     AT_MIN   SPEED is zero
//
//   Modports:
//     master   command source (drives ENABLE/UP_DOWN, observes the rest)
//     slave    speed_counter itself
// ---------------------------------------------------------------------------
interface speed_counter_if #(
    parameter int WIDTH = 3
);
    logic             ENABLE;
    logic             UP_DOWN;
    logic [WIDTH-1:0] SPEED;
    logic             TICK;
    logic             CHANGED;
    logic             AT_MAX;
    logic             AT_MIN;

    modport master (
        output ENABLE,
        output UP_DOWN,
        input  SPEED,
        input  TICK,
        input  CHANGED,
        input  AT_MAX,
        input  AT_MIN
    );

    modport slave (
        input  ENABLE,
        input  UP_DOWN,
        output SPEED,
        output TICK,
        output CHANGED,
        output AT_MAX,
        output AT_MIN
    );
endinterface

// File: rtl/speed_counter.sv
// ---------------------------------------------------------------------------
// speed_counter
//   Saturating speed-level register plus step-tick generator. Each rising
//   edge of ENABLE moves the level one step up or down (no wrap-around). The
//   level selects the period of a single-cycle TICK strobe:
//     P(L) = STEP_CYCLES * (MAX_LEVEL + 1 - L)   for L >= 1
//   Level 0 produces no ticks at all.
//
//   Ports:
//     CLK   system clock, rising edge
//     RST   synchronous active-high reset, highest priority
//     bus   speed_counter_if.slave: ENABLE, UP_DOWN in;
//           SPEED, TICK, CHANGED, AT_MAX, AT_MIN out
//
//   Parameters:
//     WIDTH        speed level width (must match the interface WIDTH)
//     MAX_LEVEL    top speed level, 1 .. 2^WIDTH-1
//     STEP_CYCLES  clock cycles per period unit
//     DIV_WIDTH    divider width, must hold STEP_CYCLES*(MAX_LEVEL+1)-1
// ---------------------------------------------------------------------------
module speed_counter #(
    parameter int WIDTH       = 3,
    parameter int MAX_LEVEL   = 7,
    parameter int STEP_CYCLES = 4,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    speed_counter_if.slave       bus
);

    localparam logic [WIDTH-1:0]     MAX_L   = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH-1:0]     ONE_L   = WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_p1, state_nxt;
    logic                 en_p1;
    logic [WIDTH-1:0]     speed_p1, speed_nxt;
    logic                 changed_p1, changed_nxt;
    logic                 tick_p1, tick_nxt;
    logic [DIV_WIDTH-1:0] div_p1, div_nxt;
    logic                 step;

    // One saturating level move; a limit leaves the level untouched.
    function automatic logic [WIDTH-1:0] sat_step(
        input logic [WIDTH-1:0] lvl,
        input logic             dn
    );
        if (!dn) begin
            return (lvl < MAX_L) ? lvl + ONE_L : lvl;
        end
        return (lvl != '0) ? lvl - ONE_L : lvl;
    endfunction

    // Terminal divider count P(L)-1 for a running level L >= 1.
    function automatic logic [DIV_WIDTH-1:0] last_count(
        input logic [WIDTH-1:0] lvl
    );
        int p;
        p = STEP_CYCLES * (MAX_LEVEL + 1 - int'(lvl));
        return DIV_WIDTH'(p - 1);
    endfunction

    // Held ENABLE yields a single step; it must drop before the next one.
    assign step = bus.ENABLE & ~en_p1;

    // ---- next-state / output decode -------------------------------------
    always_comb begin
        state_nxt   = state_p1;
        speed_nxt   = speed_p1;
        changed_nxt = 1'b0;
        div_nxt     = '0;
        tick_nxt    = 1'b0;

        if (step) begin
            speed_nxt   = sat_step(speed_p1, bus.UP_DOWN);
            changed_nxt = (speed_nxt != speed_p1);
        end

        case (state_p1)
            IDLE: begin
                // From level 0 the only possible change is an increment.
                if (changed_nxt) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (changed_nxt) begin
                    // A level change restarts the divider and drops any
                    // tick that was about to fire at the old rate.
                    if (speed_nxt == '0) begin
                        state_nxt = IDLE;
                    end
                end else if (div_p1 == last_count(speed_p1)) begin
                    tick_nxt = 1'b1;
                end else begin
                    div_nxt = div_p1 + DIV_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- registered state ------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            en_p1      <= 1'b0;
            state_p1   <= IDLE;
            speed_p1   <= '0;
            changed_p1 <= 1'b0;
            tick_p1    <= 1'b0;
            div_p1     <= '0;
        end else begin
            en_p1      <= bus.ENABLE;
            state_p1   <= state_nxt;
            speed_p1   <= speed_nxt;
            changed_p1 <= changed_nxt;
            tick_p1    <= tick_nxt;
            div_p1     <= div_nxt;
        end
    end

    assign bus.SPEED   = speed_p1;
    assign bus.TICK    = tick_p1;
    assign bus.CHANGED = changed_p1;
    assign bus.AT_MAX  = (speed_p1 == MAX_L);
    assign bus.AT_MIN  = (speed_p1 == '0);

endmodule

// File: tb/tb_speed_counter.sv
// ---------------------------------------------------------------------------
// tb_speed_counter
//   Directed scenarios followed by a random phase. Expected outputs come from
//   an event-level model: the current level, the cycle of the last accepted
//   change, and the rule that ticks fall on whole multiples of P(L) after it.
// ---------------------------------------------------------------------------
module tb_speed_counter;

    localparam int WIDTH       = 3;
    localparam int MAX_LEVEL   = 7;
    localparam int STEP_CYCLES = 4;
    localparam int DIV_WIDTH   = 16;

    logic CLK;
    logic RST;

    speed_counter_if #(.WIDTH(WIDTH)) bus ();

    speed_counter #(
        .WIDTH      (WIDTH),
        .MAX_LEVEL  (MAX_LEVEL),
        .STEP_CYCLES(STEP_CYCLES),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int t      = 0;
    int lvl    = 0;
    int t_chg  = 0;
    bit pen    = 0;
    bit exp_chg  = 0;
    bit exp_tick = 0;

    // Observed event counters
    int n_tick = 0;
    int n_chg  = 0;

    function automatic int period(input int l);
        return STEP_CYCLES * (MAX_LEVEL + 1 - l);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit ud);
        bit stp;
        t++;
        exp_chg = 0;
        if (r) begin
            lvl = 0;
            pen = 0;
        end else begin
            stp = en && !pen;
            pen = en;
            if (stp && !ud && lvl < MAX_LEVEL) begin
                lvl++;
                t_chg = t;
                exp_chg = 1;
            end else if (stp && ud && lvl > 0) begin
                lvl--;
                t_chg = t;
                exp_chg = 1;
            end
        end
        exp_tick = !r && lvl > 0 && t > t_chg && ((t - t_chg) % period(lvl)) == 0;
    endtask

    task automatic cyc(input bit r, input bit en, input bit ud);
        RST        = r;
        bus.ENABLE = en;
        bus.UP_DOWN = ud;
        @(posedge CLK);
        model_edge(r, en, ud);
        #1;
        if (bus.TICK === 1'b1) n_tick++;
        if (bus.CHANGED === 1'b1) n_chg++;
        check("speed",   32'(bus.SPEED),   32'(lvl));
        check("changed", 32'(bus.CHANGED), 32'(exp_chg));
        check("tick",    32'(bus.TICK),    32'(exp_tick));
        check("at_max",  32'(bus.AT_MAX),  32'(lvl == MAX_LEVEL));
        check("at_min",  32'(bus.AT_MIN),  32'(lvl == 0));
    endtask

    task automatic pulse(input bit ud, input int gap);
        cyc(0, 1, ud);
        for (int k = 0; k < gap; k++) cyc(0, 0, ud);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0);
    endtask

    initial begin
        int base_t;
        int base_c;
        RST = 1'b1;
        bus.ENABLE = 1'b0;
        bus.UP_DOWN = 1'b0;

        // 1: reset then a long idle stretch
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        idle(40);
        check("p1_ticks",   32'(n_tick), 32'd0);
        check("p1_changes", 32'(n_chg),  32'd0);

        // 2: three up pulses, then period-20 ticks at level 3
        for (int k = 0; k < 3; k++) pulse(0, 4);
        base_t = n_tick;
        idle(61);
        check("p2_speed", 32'(bus.SPEED), 32'd3);
        check("p2_ticks", 32'(n_tick - base_t), 32'd3);

        // 3: held ENABLE with down direction gives one step only
        base_c = n_chg;
        for (int k = 0; k < 10; k++) cyc(0, 1, 1);
        idle(50);
        check("p3_speed",   32'(bus.SPEED), 32'd2);
        check("p3_changes", 32'(n_chg - base_c), 32'd1);

        // 4: back to 0, then ten up pulses saturating at MAX_LEVEL
        pulse(1, 1);
        pulse(1, 1);
        base_c = n_chg;
        for (int k = 0; k < 10; k++) pulse(0, 1);
        check("p4_changes", 32'(n_chg - base_c), 32'd7);
        check("p4_at_max",  32'(bus.AT_MAX), 32'd1);
        base_t = n_tick;
        idle(20);
        check("p4_ticks", 32'(n_tick - base_t), 32'd5);

        // 5: down to 0, one extra down at the floor, then 1 -> 0
        for (int k = 0; k < 7; k++) pulse(1, 2);
        base_c = n_chg;
        base_t = n_tick;
        pulse(1, 30);
        check("p5_floor_chg",  32'(n_chg - base_c), 32'd0);
        check("p5_floor_tick", 32'(n_tick - base_t), 32'd0);
        pulse(0, 40);
        pulse(1, 0);
        base_t = n_tick;
        idle(60);
        check("p5_stop_tick", 32'(n_tick - base_t), 32'd0);

        // 6: reset coincident with an ENABLE rise at level 5
        for (int k = 0; k < 5; k++) pulse(0, 1);
        idle(10);
        check("p6_pre_speed", 32'(bus.SPEED), 32'd5);
        cyc(1, 1, 0);
        check("p6_speed",   32'(bus.SPEED),   32'd0);
        check("p6_changed", 32'(bus.CHANGED), 32'd0);
        base_t = n_tick;
        idle(40);
        check("p6_ticks", 32'(n_tick - base_t), 32'd0);

        // Random phase: mixed pulses, holds, directions and rare resets
        for (int i = 0; i < 1500; i++) begin
            bit r, en, ud;
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 3) == 0);
            ud = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc(r, en, ud);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
